// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access
//  Purpose  : Memory stage of the in-order pipeline. Takes execute's
//             registered outputs and performs LOAD/STORE over a req/ack
//             data-memory port. Load data is sign/zero-extended and a
//             registered writeback packet is forwarded. Execute is stalled
//             while a memory access is outstanding.
//  Config   : MISALIGN_CHECK_EN - when defined, misaligned H/HU/SH and W/SW
//             accesses raise EXC_LD_MIS / EXC_ST_MIS instead of accessing
//             memory. When undefined, the offending low address bits are
//             forced to zero and the access proceeds.
//  Ports    : clk, reset (async, active-high)
//             pipeline_in_valid, opcode_in, funct_in, nop_instr_in,
//             exception_in, exception_in_valid, result_in, addr_in,
//             rd_addr_in                          - from execute
//             stall_out                           - hold execute outputs
//             dmem_req/we/addr/wdata/be, dmem_ack/rdata - data memory port
//             pipeline_out_valid, rd_addr_out, wb_data, wb_en,
//             exception_out, exception_out_valid  - writeback packet
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int                ADDR_W     = 32,
    parameter int                EX_W       = 4,
    parameter logic [EX_W-1:0]   EXC_LD_MIS = 4,
    parameter logic [EX_W-1:0]   EXC_ST_MIS = 6
) (
    input  logic              clk,
    input  logic              reset,
    // execute side
    input  logic              pipeline_in_valid,
    input  logic [4:0]        opcode_in,
    input  logic [2:0]        funct_in,
    input  logic              nop_instr_in,
    input  logic [EX_W-1:0]   exception_in,
    input  logic              exception_in_valid,
    input  logic [31:0]       result_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [4:0]        rd_addr_in,
    output logic              stall_out,
    // data memory port
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    // writeback packet
    output logic              pipeline_out_valid,
    output logic [4:0]        rd_addr_out,
    output logic [31:0]       wb_data,
    output logic              wb_en,
    output logic [EX_W-1:0]   exception_out,
    output logic              exception_out_valid
);

    localparam logic [4:0] c_op_load  = 5'b00000;
    localparam logic [4:0] c_op_store = 5'b01000;

    localparam logic [1:0] c_sz_byte  = 2'd0;
    localparam logic [1:0] c_sz_half  = 2'd1;
    localparam logic [1:0] c_sz_word  = 2'd2;

`ifdef MISALIGN_CHECK_EN
    localparam logic c_mis_chk_en = 1'b1;
`else
    localparam logic c_mis_chk_en = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;

    // Access context latched at accept, used when the ack returns
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_is_load;
    logic [4:0]  r_rd;
    logic [31:0] r_result;

    // Request decode of the execute-side inputs
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Load data path
    logic [31:0] w_lane;
    logic [31:0] w_load_data;

    assign stall_out = (r_state == S_BUSY);

    always_comb begin
        w_is_load    = (opcode_in == c_op_load);
        w_is_store   = (opcode_in == c_op_store);
        w_is_mem     = w_is_load || w_is_store;

        // funct[1:0] selects width; anything that is not B or H (including
        // undefined encodings) is handled as a full word.
        if (funct_in[1:0] == 2'b00)
            w_size = c_sz_byte;
        else if (funct_in[1:0] == 2'b01)
            w_size = c_sz_half;
        else
            w_size = c_sz_word;

        // Low address bits that don't fit the access width are dropped, so
        // a misaligned access (when allowed through) hits the aligned lane.
        w_off        = 2'b00;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = result_in;
        case (w_size)
            c_sz_byte: begin
                w_off   = addr_in[1:0];
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{result_in[7:0]}};
            end
            c_sz_half: begin
                w_off        = {addr_in[1], 1'b0};
                w_misaligned = addr_in[0];
                w_be         = 4'b0011 << w_off;
                w_wdata      = {2{result_in[15:0]}};
            end
            default: begin
                w_off        = 2'b00;
                w_misaligned = (addr_in[1:0] != 2'b00);
                w_be         = 4'b1111;
                w_wdata      = result_in;
            end
        endcase
    end

    always_comb begin
        w_lane      = dmem_rdata >> {r_off, 3'b000};
        w_load_data = w_lane;
        case (r_size)
            c_sz_byte: w_load_data = r_unsigned ? {24'd0, w_lane[7:0]}
                                                : {{24{w_lane[7]}}, w_lane[7:0]};
            c_sz_half: w_load_data = r_unsigned ? {16'd0, w_lane[15:0]}
                                                : {{16{w_lane[15]}}, w_lane[15:0]};
            default:   w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_off               <= 2'b00;
            r_size              <= c_sz_word;
            r_unsigned          <= 1'b0;
            r_is_load           <= 1'b0;
            r_rd                <= 5'd0;
            r_result            <= 32'd0;
            dmem_req            <= 1'b0;
            dmem_we             <= 1'b0;
            dmem_addr           <= '0;
            dmem_wdata          <= 32'd0;
            dmem_be             <= 4'b0000;
            pipeline_out_valid  <= 1'b0;
            rd_addr_out         <= 5'd0;
            wb_data             <= 32'd0;
            wb_en               <= 1'b0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
        end else begin
            // Packet valid is a single-cycle pulse per instruction
            pipeline_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pipeline_in_valid) begin
                        if (nop_instr_in || exception_in_valid || !w_is_mem) begin
                            pipeline_out_valid  <= 1'b1;
                            rd_addr_out         <= rd_addr_in;
                            wb_data             <= result_in;
                            wb_en               <= !nop_instr_in && !exception_in_valid
                                                   && (rd_addr_in != 5'd0);
                            exception_out       <= exception_in_valid ? exception_in : '0;
                            exception_out_valid <= exception_in_valid;
                        end else if (c_mis_chk_en && w_misaligned) begin
                            pipeline_out_valid  <= 1'b1;
                            rd_addr_out         <= rd_addr_in;
                            wb_data             <= result_in;
                            wb_en               <= 1'b0;
                            exception_out       <= w_is_load ? EXC_LD_MIS : EXC_ST_MIS;
                            exception_out_valid <= 1'b1;
                        end else begin
                            r_state    <= S_BUSY;
                            dmem_req   <= 1'b1;
                            dmem_we    <= w_is_store;
                            dmem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
                            r_off      <= w_off;
                            r_size     <= w_size;
                            r_unsigned <= funct_in[2];
                            r_is_load  <= w_is_load;
                            r_rd       <= rd_addr_in;
                            r_result   <= result_in;
                        end
                    end
                end
                S_BUSY: begin
                    // Request fields are held untouched until the ack edge
                    if (dmem_ack) begin
                        r_state             <= S_IDLE;
                        dmem_req            <= 1'b0;
                        dmem_we             <= 1'b0;
                        pipeline_out_valid  <= 1'b1;
                        rd_addr_out         <= r_rd;
                        wb_data             <= r_is_load ? w_load_data : r_result;
                        wb_en               <= r_is_load && (r_rd != 5'd0);
                        exception_out       <= '0;
                        exception_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Directed, self-checking bench for mem_access. Expected
//             writeback packets are queued when an instruction is driven and
//             popped when the packet is due. Honours MISALIGN_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int ADDR_W = 32;
    localparam int EX_W   = 4;

    localparam logic [4:0] c_op_load  = 5'b00000;
    localparam logic [4:0] c_op_store = 5'b01000;
    localparam logic [4:0] c_op_alu   = 5'b01100;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipeline_in_valid;
    logic [4:0]        opcode_in;
    logic [2:0]        funct_in;
    logic              nop_instr_in;
    logic [EX_W-1:0]   exception_in;
    logic              exception_in_valid;
    logic [31:0]       result_in;
    logic [ADDR_W-1:0] addr_in;
    logic [4:0]        rd_addr_in;
    logic              stall_out;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic              pipeline_out_valid;
    logic [4:0]        rd_addr_out;
    logic [31:0]       wb_data;
    logic              wb_en;
    logic [EX_W-1:0]   exception_out;
    logic              exception_out_valid;

    typedef struct {
        logic [4:0]      rd;
        logic [31:0]     data;
        logic            en;
        logic            chk_data;
        logic [EX_W-1:0] exc;
        logic            excv;
    } pkt_t;

    pkt_t q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    mem_access #(
        .ADDR_W    (ADDR_W),
        .EX_W      (EX_W),
        .EXC_LD_MIS(4'd4),
        .EXC_ST_MIS(4'd6)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .pipeline_in_valid  (pipeline_in_valid),
        .opcode_in          (opcode_in),
        .funct_in           (funct_in),
        .nop_instr_in       (nop_instr_in),
        .exception_in       (exception_in),
        .exception_in_valid (exception_in_valid),
        .result_in          (result_in),
        .addr_in            (addr_in),
        .rd_addr_in         (rd_addr_in),
        .stall_out          (stall_out),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .pipeline_out_valid (pipeline_out_valid),
        .rd_addr_out        (rd_addr_out),
        .wb_data            (wb_data),
        .wb_en              (wb_en),
        .exception_out      (exception_out),
        .exception_out_valid(exception_out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic en,
                        input logic chk_data, input logic [EX_W-1:0] exc, input logic excv);
        pkt_t p;
        p.rd = rd; p.data = data; p.en = en; p.chk_data = chk_data;
        p.exc = exc; p.excv = excv;
        q.push_back(p);
    endtask

    // Called at the negedge where a packet is due
    task automatic check_packet(input string tag);
        pkt_t e;
        check({tag, "_valid"}, {31'd0, pipeline_out_valid}, 32'd1);
        check({tag, "_sb_entry"}, {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_rd"}, {27'd0, rd_addr_out}, {27'd0, e.rd});
            check({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, e.en});
            if (e.chk_data)
                check({tag, "_wb_data"}, wb_data, e.data);
            check({tag, "_exc_valid"}, {31'd0, exception_out_valid}, {31'd0, e.excv});
            if (e.excv)
                check({tag, "_exc"}, {28'd0, exception_out}, {28'd0, e.exc});
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f, input logic nop,
                         input logic excv, input logic [EX_W-1:0] exc,
                         input logic [31:0] res, input logic [31:0] addr, input logic [4:0] rd);
        pipeline_in_valid  = 1'b1;
        opcode_in          = op;
        funct_in           = f;
        nop_instr_in       = nop;
        exception_in_valid = excv;
        exception_in       = exc;
        result_in          = res;
        addr_in            = addr;
        rd_addr_in         = rd;
    endtask

    // Single-cycle path: packet due one negedge after drive, no access
    task automatic single_step(input string tag);
        @(negedge clk);
        pipeline_in_valid = 1'b0;
        check_packet(tag);
        check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        check({tag, "_drop"}, {31'd0, pipeline_out_valid}, 32'd0);
    endtask

    // Memory path: inputs already driven; ack raised in the ack_delay-th busy cycle
    task automatic mem_op(input string tag, input int ack_delay, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_be, input logic e_we);
        for (int k = 1; k <= ack_delay; k++) begin
            @(negedge clk);
            pipeline_in_valid = 1'b0;
            check({tag, "_stall"}, {31'd0, stall_out}, 32'd1);
            check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
            check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, e_we});
            check({tag, "_addr"}, dmem_addr, e_addr);
            check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, e_be});
            if (e_we)
                check({tag, "_wdata"}, dmem_wdata, e_wdata);
            check({tag, "_busy_nopkt"}, {31'd0, pipeline_out_valid}, 32'd0);
            if (k == ack_delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        check({tag, "_stall_done"}, {31'd0, stall_out}, 32'd0);
        check({tag, "_req_done"}, {31'd0, dmem_req}, 32'd0);
        check_packet(tag);
        @(negedge clk);
        check({tag, "_drop"}, {31'd0, pipeline_out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pipeline_in_valid = 1'b0; opcode_in = 5'd0; funct_in = 3'd0; nop_instr_in = 1'b0;
        exception_in = '0; exception_in_valid = 1'b0; result_in = 32'd0;
        addr_in = '0; rd_addr_in = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_pov", {31'd0, pipeline_out_valid}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_excv", {31'd0, exception_out_valid}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ALU op back-to-back x3: one packet per cycle, never stalls
        drive(c_op_alu, 3'b000, 1'b0, 1'b0, '0, 32'h55, 32'h0, 5'd5);
        for (int i = 0; i < 3; i++) begin
            push(5'd5, 32'h55, 1'b1, 1'b1, '0, 1'b0);
            @(negedge clk);
            check_packet("add_b2b");
            check("add_b2b_stall", {31'd0, stall_out}, 32'd0);
            check("add_b2b_req", {31'd0, dmem_req}, 32'd0);
        end
        pipeline_in_valid = 1'b0;
        @(negedge clk);
        check("add_b2b_drop", {31'd0, pipeline_out_valid}, 32'd0);

        // rd == 0 suppresses writeback
        drive(c_op_alu, 3'b000, 1'b0, 1'b0, '0, 32'h77, 32'h0, 5'd0);
        push(5'd0, 32'h77, 1'b0, 1'b1, '0, 1'b0);
        single_step("add_rd0");

        // Bubble carrying a LOAD opcode: no access, no writeback
        drive(c_op_load, 3'b010, 1'b1, 1'b0, '0, 32'h99, 32'h40, 5'd4);
        push(5'd4, 32'h99, 1'b0, 1'b1, '0, 1'b0);
        single_step("nop");

        // LB / LBU at byte 3, 3-cycle ack
        drive(c_op_load, 3'b000, 1'b0, 1'b0, '0, 32'h0, 32'h103, 5'd7);
        push(5'd7, 32'hFFFF_FF80, 1'b1, 1'b1, '0, 1'b0);
        mem_op("lb", 3, 32'h8000_0000, 32'h100, 32'h0, 4'b1000, 1'b0);
        drive(c_op_load, 3'b100, 1'b0, 1'b0, '0, 32'h0, 32'h103, 5'd8);
        push(5'd8, 32'h0000_0080, 1'b1, 1'b1, '0, 1'b0);
        mem_op("lbu", 3, 32'h8000_0000, 32'h100, 32'h0, 4'b1000, 1'b0);

        // LH upper half with zero-wait ack; LHU lower half
        drive(c_op_load, 3'b001, 1'b0, 1'b0, '0, 32'h0, 32'h302, 5'd9);
        push(5'd9, 32'hFFFF_8001, 1'b1, 1'b1, '0, 1'b0);
        mem_op("lh_zw", 1, 32'h8001_0000, 32'h300, 32'h0, 4'b1100, 1'b0);
        drive(c_op_load, 3'b101, 1'b0, 1'b0, '0, 32'h0, 32'h300, 5'd10);
        push(5'd10, 32'h0000_F00F, 1'b1, 1'b1, '0, 1'b0);
        mem_op("lhu", 2, 32'h1234_F00F, 32'h300, 32'h0, 4'b0011, 1'b0);

        // Stores: lane enables and replicated data, no writeback
        drive(c_op_store, 3'b001, 1'b0, 1'b0, '0, 32'h1234_ABCD, 32'h202, 5'd11);
        push(5'd11, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        mem_op("sh", 2, 32'h0, 32'h200, 32'hABCD_ABCD, 4'b1100, 1'b1);
        drive(c_op_store, 3'b000, 1'b0, 1'b0, '0, 32'h0000_00A5, 32'h201, 5'd11);
        push(5'd11, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        mem_op("sb", 1, 32'h0, 32'h200, 32'hA5A5_A5A5, 4'b0010, 1'b1);
        drive(c_op_store, 3'b010, 1'b0, 1'b0, '0, 32'hCAFE_BABE, 32'h204, 5'd3);
        push(5'd3, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        mem_op("sw", 2, 32'h0, 32'h204, 32'hCAFE_BABE, 4'b1111, 1'b1);

        // LW to x0: data returned but not written
        drive(c_op_load, 3'b010, 1'b0, 1'b0, '0, 32'h0, 32'h40, 5'd0);
        push(5'd0, 32'h1357_9BDF, 1'b0, 1'b1, '0, 1'b0);
        mem_op("lw_rd0", 2, 32'h1357_9BDF, 32'h40, 32'h0, 4'b1111, 1'b0);

        // Misaligned word load and half store
`ifdef MISALIGN_CHECK_EN
        drive(c_op_load, 3'b010, 1'b0, 1'b0, '0, 32'h0, 32'h101, 5'd12);
        push(5'd12, 32'h0, 1'b0, 1'b0, 4'd4, 1'b1);
        single_step("lw_mis");
        drive(c_op_store, 3'b001, 1'b0, 1'b0, '0, 32'h0000_BEEF, 32'h203, 5'd12);
        push(5'd12, 32'h0, 1'b0, 1'b0, 4'd6, 1'b1);
        single_step("sh_mis");
`else
        drive(c_op_load, 3'b010, 1'b0, 1'b0, '0, 32'h0, 32'h101, 5'd12);
        push(5'd12, 32'h1122_3344, 1'b1, 1'b1, '0, 1'b0);
        mem_op("lw_mis", 1, 32'h1122_3344, 32'h100, 32'h0, 4'b1111, 1'b0);
        drive(c_op_store, 3'b001, 1'b0, 1'b0, '0, 32'h0000_BEEF, 32'h203, 5'd12);
        push(5'd12, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        mem_op("sh_mis", 1, 32'h0, 32'h200, 32'hBEEF_BEEF, 4'b1100, 1'b1);
`endif

        // Upstream exception on a STORE: no access, code forwarded
        drive(c_op_store, 3'b010, 1'b0, 1'b1, 4'd2, 32'hDEAD, 32'h208, 5'd3);
        push(5'd3, 32'hDEAD, 1'b0, 1'b1, 4'd2, 1'b1);
        single_step("st_exc");

        // Reset while a request is outstanding
        drive(c_op_load, 3'b010, 1'b0, 1'b0, '0, 32'h0, 32'h80, 5'd13);
        @(negedge clk);
        pipeline_in_valid = 1'b0;
        check("rstb_req_before", {31'd0, dmem_req}, 32'd1);
        check("rstb_stall_before", {31'd0, stall_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstb_req", {31'd0, dmem_req}, 32'd0);
        check("rstb_stall", {31'd0, stall_out}, 32'd0);
        check("rstb_pov", {31'd0, pipeline_out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_pov", {31'd0, pipeline_out_valid}, 32'd0);
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall_out}, 32'd0);

        // Normal operation resumes after reset
        drive(c_op_alu, 3'b000, 1'b0, 1'b0, '0, 32'hA1, 32'h0, 5'd14);
        push(5'd14, 32'hA1, 1'b1, 1'b1, '0, 1'b0);
        single_step("post_rst_alu");
        drive(c_op_load, 3'b000, 1'b0, 1'b0, '0, 32'h0, 32'h0, 5'd15);
        push(5'd15, 32'h0000_007F, 1'b1, 1'b1, '0, 1'b0);
        mem_op("post_rst_lb", 2, 32'hFFFF_FF7F, 32'h0, 32'h0, 4'b0001, 1'b0);

        check("sb_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
